mc_ctrl: RTL
============

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameter MAX_WAIT, default 15: memory wait cycles allowed before timeout.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 Op  input  6  instruction opcode from the instruction register.
REQ-005 Funct  input  6  R-type function field from the instruction register.
REQ-006 Zero  input  1  ALU zero flag.
REQ-007 MemReady  input  1  memory completion, valid while MemReq=1.
REQ-008 MemReq / MemWrite / IorD  output  1 each  memory request, write enable, address select (0 PC, 1 ALUOut).
REQ-009 IRWrite / PCWrite / RegWrite  output  1 each  register load strobes.
REQ-010 RegDst  output  2  write target: 0 rt, 1 rd, 2 $31.
REQ-011 MemtoReg  output  2  write-back source: 0 ALUOut, 1 memory data, 2 PC.
REQ-012 ALUsrcA  output  1  ALU A select: 0 PC, 1 rs.
REQ-013 ALUsrcB  output  2  ALU B select: 0 rt, 1 const 4, 2 ext imm, 3 ext imm<<2.
REQ-014 ExtOp  output  2  extender: 0 zero, 1 sign, 2 load-upper.
REQ-015 ALUOp  output  4  0000 add, 0001 sub, 0010 or, 0011 sll, 1000 slt.
REQ-016 PCSrc  output  2  next PC: 0 ALU, 1 ALUOut, 2 jump target, 3 rs.
REQ-017 Illegal  output  1  sticky error flag; State  output  3  current state.

Function
REQ-018 Supported set SHALL be addu, subu, sll, slt, jr, ori, lui, lw, sw, beq, jal; any other Op/Funct is illegal.
REQ-019 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERR=7; outputs are combinational from state, Op, Funct, Zero, MemReady.
REQ-020 All strobes not listed for a state SHALL be 0.
REQ-021 FETCH: MemReq=1, IorD=0, ALUsrcA=0, ALUsrcB=1, ALUOp=add; hold until MemReady; in the MemReady cycle IRWrite=1, PCWrite=1, PCSrc=0, next DECODE.
REQ-022 DECODE: ALUsrcA=0, ALUsrcB=3, ExtOp=1, ALUOp=add (branch target to ALUOut); illegal -> ERR.
REQ-023 DECODE jal: PCWrite=1, PCSrc=2, RegWrite=1, RegDst=2, MemtoReg=2 -> FETCH; jr: PCWrite=1, PCSrc=3 -> FETCH; others -> EXEC.
REQ-024 EXEC: ALUsrcA=1; R-type ALUsrcB=0; ori ExtOp=0, lui ExtOp=2, lw/sw ExtOp=1, all ALUsrcB=2.
REQ-025 EXEC beq: ALUOp=sub, ALUsrcB=0, PCWrite=Zero, PCSrc=1 -> FETCH; lw/sw -> MEM; others -> WB.
REQ-026 MEM: MemReq=1, IorD=1, MemWrite=sw; hold until MemReady; sw -> FETCH, lw -> WB.
REQ-027 WB: RegWrite=1; R-type RegDst=1, MemtoReg=0; ori/lui RegDst=0, MemtoReg=0; lw RegDst=0, MemtoReg=1; -> FETCH.
REQ-028 Latency with zero-wait memory: jal/jr 2, beq 3, R-type/imm/sw 4, lw 5 cycles.
REQ-029 Wait counter SHALL clear on entry to FETCH/MEM and increment each cycle MemReady=0; reaching MAX_WAIT without MemReady -> ERR.
REQ-030 MemReady in the cycle the counter reaches MAX_WAIT SHALL count as success.
REQ-031 ERR: all strobes 0, Illegal=1, state held until reset.
REQ-032 MemReady outside FETCH/MEM SHALL be ignored.

Reset
REQ-033 reset=0 SHALL immediately force State=FETCH, counter=0, Illegal=0, all strobes 0, independent of clk.
REQ-034 reset asserted mid-MEM SHALL drop MemReq/MemWrite in the same cycle; after release the block restarts at FETCH with MemReq=1.

Verification
REQ-035 addu (Op=0, Funct=0x21), MemReady=1 -> States 0,1,2,4,0; WB RegWrite=1, RegDst=1.
REQ-036 lw (Op=0x23), MemReady low 3 cycles in MEM -> MEM held 4 cycles, IorD=1, then WB MemtoReg=1.
REQ-037 beq Zero=1 then Zero=0 -> PCWrite=1/PCSrc=1 in EXEC, then PCWrite=0; both return to FETCH.
REQ-038 jal (Op=0x03) -> DECODE asserts PCWrite, PCSrc=2, RegWrite, RegDst=2, MemtoReg=2; 2-cycle total.
REQ-039 Op=0x3F -> ERR after DECODE, Illegal=1 held 20 cycles; reset clears to FETCH.
REQ-040 MemReady=0 for 15 cycles in FETCH -> ERR; ready on 15th cycle -> DECODE; reset pulse mid-sw -> MemWrite=0 immediately.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multicycle MIPS-subset control unit: FETCH/DECODE/EXEC/MEM/WB sequencing,
// memory wait timeout and sticky illegal-instruction error state.
module mc_ctrl #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       ALUsrcA,
  output logic [1:0] ALUsrcB,
  output logic [1:0] ExtOp,
  output logic [3:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       Illegal,
  output logic [2:0] State
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b1000;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd7
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic wait_expired;

  logic is_r, is_addu, is_subu, is_sll, is_slt, is_jr;
  logic is_ori, is_lui, is_lw, is_sw, is_beq, is_jal, legal;

  logic       memreq_c, memwrite_c, iord_c, irwrite_c, pcwrite_c, regwrite_c;
  logic [1:0] regdst_c, memtoreg_c, alusrcb_c, extop_c, pcsrc_c;
  logic       alusrca_c, illegal_c;
  logic [3:0] aluop_c, r_aluop;

  // Instruction decode from the IR opcode/function fields
  assign is_r    = (Op == 6'h00);
  assign is_addu = is_r && (Funct == 6'h21);
  assign is_subu = is_r && (Funct == 6'h23);
  assign is_sll  = is_r && (Funct == 6'h00);
  assign is_slt  = is_r && (Funct == 6'h2A);
  assign is_jr   = is_r && (Funct == 6'h08);
  assign is_ori  = (Op == 6'h0D);
  assign is_lui  = (Op == 6'h0F);
  assign is_lw   = (Op == 6'h23);
  assign is_sw   = (Op == 6'h2B);
  assign is_beq  = (Op == 6'h04);
  assign is_jal  = (Op == 6'h03);
  assign legal   = is_addu | is_subu | is_sll | is_slt | is_jr | is_ori |
                   is_lui | is_lw | is_sw | is_beq | is_jal;

  // Memory wait budget exhausted if this cycle is also not ready
  assign wait_expired = (cnt_q == CW'(MAX_WAIT - 1));

  // R-type ALU function select
  always_comb begin
    r_aluop = ALU_ADD;
    if (is_subu)     r_aluop = ALU_SUB;
    else if (is_sll) r_aluop = ALU_SLL;
    else if (is_slt) r_aluop = ALU_SLT;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Wait counter: cleared on any state change, counts not-ready memory cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt_q <= '0;
    else if (state_d != state_q)
      cnt_q <= '0;
    else if ((state_q == S_FETCH || state_q == S_MEM) && !MemReady)
      cnt_q <= cnt_q + CW'(1);
  end

  // Next state and per-state control decode
  always_comb begin
    state_d    = state_q;
    memreq_c   = 1'b0;
    memwrite_c = 1'b0;
    iord_c     = 1'b0;
    irwrite_c  = 1'b0;
    pcwrite_c  = 1'b0;
    regwrite_c = 1'b0;
    regdst_c   = 2'd0;
    memtoreg_c = 2'd0;
    alusrca_c  = 1'b0;
    alusrcb_c  = 2'd0;
    extop_c    = 2'd0;
    aluop_c    = ALU_ADD;
    pcsrc_c    = 2'd0;
    illegal_c  = 1'b0;
    case (state_q)
      S_FETCH: begin
        memreq_c  = 1'b1;
        alusrcb_c = 2'd1;
        if (MemReady) begin
          irwrite_c = 1'b1;
          pcwrite_c = 1'b1;
          state_d   = S_DECODE;
        end else if (wait_expired) begin
          state_d = S_ERR;
        end
      end
      S_DECODE: begin
        alusrcb_c = 2'd3;
        extop_c   = 2'd1;
        if (!legal) begin
          state_d = S_ERR;
        end else if (is_jal) begin
          pcwrite_c  = 1'b1;
          pcsrc_c    = 2'd2;
          regwrite_c = 1'b1;
          regdst_c   = 2'd2;
          memtoreg_c = 2'd2;
          state_d    = S_FETCH;
        end else if (is_jr) begin
          pcwrite_c = 1'b1;
          pcsrc_c   = 2'd3;
          state_d   = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alusrca_c = 1'b1;
        if (is_r) begin
          aluop_c = r_aluop;
          state_d = S_WB;
        end else if (is_beq) begin
          aluop_c   = ALU_SUB;
          pcwrite_c = Zero;
          pcsrc_c   = 2'd1;
          state_d   = S_FETCH;
        end else begin
          alusrcb_c = 2'd2;
          if (is_ori) begin
            aluop_c = ALU_OR;
          end else if (is_lui) begin
            extop_c = 2'd2;
          end else begin
            extop_c = 2'd1;
          end
          state_d = (is_lw || is_sw) ? S_MEM : S_WB;
        end
      end
      S_MEM: begin
        memreq_c   = 1'b1;
        iord_c     = 1'b1;
        memwrite_c = is_sw;
        if (MemReady)          state_d = is_sw ? S_FETCH : S_WB;
        else if (wait_expired) state_d = S_ERR;
      end
      S_WB: begin
        regwrite_c = 1'b1;
        if (is_r)  regdst_c   = 2'd1;
        if (is_lw) memtoreg_c = 2'd1;
        state_d = S_FETCH;
      end
      S_ERR: begin
        illegal_c = 1'b1;
      end
      default: state_d = S_ERR;
    endcase
  end

  // Reset forces every control output low immediately
  assign MemReq   = reset & memreq_c;
  assign MemWrite = reset & memwrite_c;
  assign IorD     = reset & iord_c;
  assign IRWrite  = reset & irwrite_c;
  assign PCWrite  = reset & pcwrite_c;
  assign RegWrite = reset & regwrite_c;
  assign ALUsrcA  = reset & alusrca_c;
  assign Illegal  = reset & illegal_c;
  assign RegDst   = reset ? regdst_c   : 2'd0;
  assign MemtoReg = reset ? memtoreg_c : 2'd0;
  assign ALUsrcB  = reset ? alusrcb_c  : 2'd0;
  assign ExtOp    = reset ? extop_c    : 2'd0;
  assign ALUOp    = reset ? aluop_c    : 4'd0;
  assign PCSrc    = reset ? pcsrc_c    : 2'd0;
  assign State    = state_q;

endmodule
